// File: rtl/spi_pkg.sv
// Shared field positions, SPI mode encoding and edge-count constants for spi_master_multi.
package spi_pkg;

    localparam int TX_LSB    = 0;
    localparam int CS_BIT    = 8;
    localparam int CHAN_LSB  = 9;
    localparam int MODE_LSB  = 12;
    localparam int ORDER_BIT = 14;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    localparam int                EDGE_W    = 5;
    localparam logic [EDGE_W-1:0] LAST_EDGE = 5'd16;

    function automatic logic mode_cpol(input spi_mode_e m);
        return m[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_e m);
        return m[0];
    endfunction

endpackage

// File: rtl/spi_master_multi_if.sv
// CPU I/O bus side of spi_master_multi: command strobe, command word and read-back word.
interface spi_master_multi_if;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;

    modport master (output load, output in, input  out);
    modport slave  (input  load, input  in, output out);
endinterface

// File: rtl/spi_clkgen.sv
// SCK divider and edge counter; strobes mark the clk edge on which sck toggles.
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic load_sck,
    input  logic cpol,
    input  logic run,
    output logic sck_q,
    output logic lead_stb,
    output logic trail_stb,
    output logic done_stb
);

    localparam int            DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0]     div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic              tick;

    // edge_cnt holds completed toggles, so the upcoming toggle is leading when it is even
    always_comb begin
        tick      = run && (div_cnt == DIV_LAST);
        lead_stb  = tick && !edge_cnt[0];
        trail_stb = tick && edge_cnt[0];
        done_stb  = tick && (edge_cnt == (LAST_EDGE - 1'b1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            sck_q    <= 1'b0;
        end else begin
            if (start) begin
                div_cnt  <= '0;
                edge_cnt <= '0;
            end else if (tick) begin
                div_cnt  <= '0;
                edge_cnt <= edge_cnt + 1'b1;
            end else if (run) begin
                div_cnt  <= div_cnt + 1'b1;
            end

            if (load_sck)
                sck_q <= cpol;
            else if (tick)
                sck_q <= ~sck_q;
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// Memory-mapped multi-CS SPI master, all four modes. Optional LSB-first ordering under SPI_LSB_FIRST_EN.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int NUM_CS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_multi_if.slave bus,
    output logic [NUM_CS-1:0] csx,
    output logic              sck,
    output logic              sdo,
    input  logic              sdi
);

    logic       busy;
    logic       accept;
    logic       start;
    logic       cs_lvl;
    logic [2:0] chan;
    spi_mode_e  mode_q;
    logic [7:0] shift;
    logic       sample;
    logic       lsb_first;
    logic       in_bit;
    logic       lead_stb;
    logic       trail_stb;
    logic       done_stb;

    always_comb begin
        chan    = bus.in[CHAN_LSB +: 3];
        cs_lvl  = bus.in[CS_BIT];
        accept  = bus.load && !busy;
        start   = accept && !cs_lvl;
        in_bit  = mode_cpha(mode_q) ? sdi : sample;
        sdo     = lsb_first ? shift[0] : shift[7];
        bus.out = {busy, 7'd0, shift};
    end

`ifdef SPI_LSB_FIRST_EN
    always_ff @(posedge clk) begin
        if (reset)
            lsb_first <= 1'b0;
        else if (accept)
            lsb_first <= bus.in[ORDER_BIT];
    end
`else
    assign lsb_first = 1'b0;
`endif

    spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_sck  (accept),
        .cpol      (bus.in[MODE_LSB + 1]),
        .run       (busy),
        .sck_q     (sck),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .done_stb  (done_stb)
    );

    // Out-of-range channel indices match no bit, so csx is left alone
    always_ff @(posedge clk) begin
        if (reset) begin
            csx <= '1;
        end else begin
            for (int unsigned i = 0; i < NUM_CS; i++)
                if (accept && (32'(chan) == i))
                    csx[i] <= cs_lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            mode_q <= MODE0;
            shift  <= '0;
            sample <= 1'b0;
        end else begin
            if (accept)
                mode_q <= spi_mode_e'(bus.in[MODE_LSB +: 2]);

            if (start) begin
                busy  <= 1'b1;
                shift <= bus.in[TX_LSB +: 8];
            end else begin
                if (done_stb)
                    busy <= 1'b0;
                if (lead_stb && !mode_cpha(mode_q))
                    sample <= sdi;
                if (trail_stb)
                    shift <= lsb_first ? {in_bit, shift[7:1]} : {shift[6:0], in_bit};
            end
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi (CLK_DIV=2, NUM_CS=4) with a behavioural SPI slave.
module tb_spi_master_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] csx;
    logic       sck;
    logic       sdo;
    logic       sdi;

    spi_master_multi_if bus ();

    spi_master_multi #(.CLK_DIV(2), .NUM_CS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .csx   (csx),
        .sck   (sck),
        .sdo   (sdo),
        .sdi   (sdi)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model: CPHA=0 presents bits before the leading edge and advances on trailing;
    // CPHA=1 advances on leading. sdo is recorded at every leading edge.
    logic       xfer_on = 1'b0;
    logic       cpol_v, cpha_v;
    logic [7:0] slave_byte;
    logic [7:0] sdo_bits;
    int         idx;
    int         leads;

    always @(sck) begin
        if (xfer_on) begin
            if (sck != cpol_v) begin
                leads++;
                sdo_bits = {sdo_bits[6:0], sdo};
                if (cpha_v) begin
                    if (idx < 8) sdi = slave_byte[7 - idx];
                    idx++;
                end
            end else if (!cpha_v) begin
                idx++;
                if (idx < 8) sdi = slave_byte[7 - idx];
            end
        end
    end

    task automatic run_xfer(input logic [15:0] cmd, input logic [7:0] sbyte,
                            input logic [15:0] mid_cmd, input int mid_at, output int busy_n);
        slave_byte = sbyte;
        cpol_v     = cmd[13];
        cpha_v     = cmd[12];
        idx        = 0;
        leads      = 0;
        sdo_bits   = 8'h00;
        sdi        = cpha_v ? 1'b0 : sbyte[7];
        @(negedge clk);
        bus.load = 1'b1;
        bus.in   = cmd;
        @(negedge clk);
        bus.load = 1'b0;
        xfer_on  = 1'b1;
        busy_n   = 0;
        while (bus.out[15] && busy_n < 200) begin
            busy_n++;
            if (mid_at != 0 && busy_n == mid_at) begin
                bus.load = 1'b1;
                bus.in   = mid_cmd;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        xfer_on  = 1'b0;
        if (busy_n >= 200) check("busy_timeout", 32'(busy_n), 32'd32);
    endtask

    task automatic send_cmd(input logic [15:0] cmd);
        @(negedge clk);
        bus.load = 1'b1;
        bus.in   = cmd;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    int n;

    initial begin
        reset    = 1'b1;
        bus.load = 1'b1;
        bus.in   = 16'h00A5;
        sdi      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csx", 32'(csx), 32'h0F);
        check("rst_sck", 32'(sck), 32'h0);
        check("rst_out", 32'(bus.out), 32'h0000);
        bus.load = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("post_rst_out", 32'(bus.out), 32'h0000);

        // Mode 0, channel 0, tx A5, slave 3C
        run_xfer(16'h00A5, 8'h3C, 16'h0000, 0, n);
        check("m0_busy_cycles", 32'(n), 32'd32);
        check("m0_sdo_bits", 32'(sdo_bits), 32'hA5);
        check("m0_leads", 32'(leads), 32'd8);
        check("m0_out", 32'(bus.out), 32'h003C);
        check("m0_csx", 32'(csx), 32'h0E);
        check("m0_sck_idle", 32'(sck), 32'h0);

        // Load during busy is ignored
        run_xfer(16'h005A, 8'hC3, 16'h0100, 10, n);
        check("ign_busy_cycles", 32'(n), 32'd32);
        check("ign_csx", 32'(csx), 32'h0E);
        check("ign_out", 32'(bus.out), 32'h00C3);
        check("ign_sdo_bits", 32'(sdo_bits), 32'h5A);

        // Deassert channel 0 while idle: no transfer, shift retained
        send_cmd(16'h0100);
        check("deassert_csx", 32'(csx), 32'h0F);
        check("deassert_out", 32'(bus.out), 32'h00C3);

        // Mode 3, channel 2: CS-only command first moves idle sck to CPOL
        send_cmd(16'h3500);
        check("m3_idle_sck_pre", 32'(sck), 32'h1);
        check("m3_cs_only_out", 32'(bus.out), 32'h00C3);
        run_xfer(16'h34F0, 8'h81, 16'h0000, 0, n);
        check("m3_busy_cycles", 32'(n), 32'd32);
        check("m3_sdo_bits", 32'(sdo_bits), 32'hF0);
        check("m3_out", 32'(bus.out), 32'h0081);
        check("m3_csx", 32'(csx), 32'h0B);
        check("m3_idle_sck_post", 32'(sck), 32'h1);

        // Reset in the middle of a mode 0 transfer on channel 0
        slave_byte = 8'hFF;
        cpol_v = 1'b0; cpha_v = 1'b0;
        send_cmd(16'h00FF);
        repeat (13) @(negedge clk);
        check("mid_busy", 32'(bus.out[15]), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_out", 32'(bus.out), 32'h0000);
        check("mid_rst_sck", 32'(sck), 32'h0);
        check("mid_rst_csx", 32'(csx), 32'h0F);
        run_xfer(16'h0296, 8'h5A, 16'h0000, 0, n);
        check("clean_busy_cycles", 32'(n), 32'd32);
        check("clean_sdo_bits", 32'(sdo_bits), 32'h96);
        check("clean_out", 32'(bus.out), 32'h005A);
        check("clean_csx", 32'(csx), 32'h0D);

        // Out-of-range channel index: accepted, csx untouched
        send_cmd(16'h0F00);
        check("oor_csx", 32'(csx), 32'h0D);

`ifdef SPI_LSB_FIRST_EN
        run_xfer(16'h4001, 8'h80, 16'h0000, 0, n);
        check("lsb_sdo_bits", 32'(sdo_bits), 32'h80);
        check("lsb_out", 32'(bus.out), 32'h0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
- Parametrised successor to the single-channel 8-bit SPI port. Memory-mapped SPI master driven by a 16-bit command word.
- Adds a programmable SCK divider, NUM_CS independent chip selects, and all four SPI modes (CPOL/CPHA) selectable per command.
- Sits on the CPU I/O bus. Read-back word reports busy and the received byte.

Parameters:
- CLK_DIV, 1, SCK half-period in clk cycles (must be >= 1).
- NUM_CS, 4, number of chip-select outputs (1..8).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  command strobe; in is sampled on the same edge
- in  in  16  command word
- out  out  16  status/read-back: {busy, 7'd0, shift[7:0]}
- csx  out  NUM_CS  active-low chip selects
- sck  out  1  SPI clock, registered
- sdo  out  1  serial data out = shift[7] (or shift[0] in LSB mode)
- sdi  in  1  serial data in

Behaviour:
- Command fields:
  - in[7:0] tx data
  - in[8] CS level for the addressed channel
  - in[11:9] channel index
  - in[13:12] mode {CPOL,CPHA}
  - in[14] bit order (optional feature only)
  - in[15] reserved
- Reset values: csx all 1, sck 0, busy 0, shift 0, latched mode 0, counters 0. Reset mid-transfer aborts the transfer; all reset values appear after the reset edge.
- Accepted load (load=1 and busy=0), on that edge:
  - csx[in[11:9]] <= in[8]; other csx bits unchanged. A channel index >= NUM_CS leaves csx unchanged but the command is still accepted.
  - Mode is latched.
  - If in[8]=0: shift <= in[7:0], busy <= 1, div_cnt <= 0, edge_cnt <= 0.
  - If in[8]=1: the command only deasserts CS; no transfer starts.
- Load while busy=1 is ignored entirely: no csx, mode or shift change.
- Idle: sck = latched CPOL. The level changes on the accepted load edge if CPOL changes.
- Transfer timing: sck toggles every CLK_DIV clocks. The edge count runs 1..16; odd edges are leading, even edges are trailing.
  - For a load at edge t, toggle k occurs at edge t + k*CLK_DIV.
  - busy falls on toggle 16 (edge t+16*CLK_DIV). busy is high for exactly 16*CLK_DIV cycles.
  - sck is back at CPOL after toggle 16.
- CPHA=0:
  - Leading edge: sdi is captured into a sample flop.
  - Trailing edge: shift <= {shift[6:0], sample}.
  - sdo is valid from the load edge.
- CPHA=1:
  - Leading edge: no data action.
  - Trailing edge: shift <= {shift[6:0], sdi}, which also presents the next sdo bit.
- After busy falls, out[7:0] holds the received byte until the next accepted transfer load.
- csx is never changed automatically. Software deasserts it with a load carrying in[8]=1.
- Simultaneous reset and load: reset wins.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: in[14] is latched with the mode. When the latched bit is 1:
  - sdo = shift[0];
  - the trailing-edge update is shift <= {sample_or_sdi, shift[7:1]}.
  The read-back byte is then in natural bit order.
- Undefined: in[14] is ignored; transfers are always MSB first; no extra flop.

Decomposition:
- Shared package/include spi_pkg holds:
  - field-position constants: TX_LSB=0, CS_BIT=8, CHAN_LSB=9, MODE_LSB=12, ORDER_BIT=14;
  - mode encoding constants MODE0..MODE3;
  - edge-count width (5) and the last-edge constant 16.
- Sub-module spi_clkgen holds the divider counter (width $clog2(CLK_DIV+1)) and the edge counter. Its outputs:
  - sck_q;
  - lead_stb / trail_stb (one-cycle strobes);
  - done_stb.
- The top module holds the command decode, csx register, shift/sample registers and busy.

Test Plan:
- CLK_DIV=2, NUM_CS=4. Reset with load=1 held → csx=4'b1111, sck=0, out=16'h0000 after reset; the load is ignored.
- Mode 0, load in=16'h0000|8'hA5 on channel 0 with sdi driven from slave byte 8'h3C → csx=4'b1110; sdo sequence 1,0,1,0,0,1,0,1 valid at leading edges; busy high exactly 32 cycles; out=16'h003C after it falls.
- Mode 3 (in[13:12]=2'b11), channel 2, tx 8'hF0, slave 8'h81 → idle sck=1 before and after; sdo changes only after trailing (rising) edges; out=16'h0081; csx=4'b1011.
- During a busy transfer, load in=16'h0100 (deassert channel 0) → ignored; csx unchanged; transfer completes normally.
- Assert reset at edge 7 of a transfer → next cycle busy=0, sck=0, csx=4'b1111, shift=0; a following load starts a clean transfer.
- With SPI_LSB_FIRST_EN, in[14]=1, tx 8'h01 → first sdo bit is 1, rest 0; slave sends bits 1,0,0,0,0,0,0,0 → out[7:0]=8'h01.
